da_dct_engine: RTL and testbench
================================

DA_DCT_ENGINE -- requirements
Module: da_dct_engine

Interface
REQ-001 SHALL have parameter N_TAPS, default 4, meaning the number of signed input samples per dot product (range 2..8).
REQ-002 SHALL have parameter DW, default 12, meaning the input sample width (two's complement).
REQ-003 SHALL have parameter CW, default 12, meaning the signed coefficient width in Q(FRAC) format.
REQ-004 SHALL have parameter OW, default 12, meaning the output width.
REQ-005 SHALL have parameter FRAC, default 10, meaning the coefficient fractional bits removed at output.
REQ-006 SHALL have parameter N_ROWS, default 8, meaning the number of coefficient rows (DCT output indices).
REQ-007 SHALL have port sys_clk  input  1  clock; reset sys_rst_n, asynchronous, active-low; clock sys_clk.
REQ-008 SHALL have port sys_rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port in_valid  input  1  input vector and row_sel valid.
REQ-010 SHALL have port in_ready  output  1  engine can accept a vector.
REQ-011 SHALL have port x_i  input  N_TAPS*DW  packed samples, tap 0 in the MSBs.
REQ-012 SHALL have port row_sel  input  clog2(N_ROWS)  coefficient row.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-015 SHALL have port y_o  output  OW  signed result; sat_o  output  1  result was clipped.

Function
REQ-016 SHALL compute y = sum over k of x[k]*c[row][k] using bit-serial distributed arithmetic, one input bit-plane per cycle, MSB first.
REQ-017 SHALL form ROM address bit (N_TAPS-1-k) from bit b of x[k]; the ROM entry is the sum of c[row][k] over the set address bits.
REQ-018 SHALL initialise the accumulator to minus the ROM entry for bit-plane DW-1 (sign weight), then apply acc <= (acc<<1) + entry for each remaining plane.
REQ-019 SHALL use an accumulator width of CW+DW+clog2(N_TAPS)+1 bits, with no internal overflow.
REQ-020 SHALL produce y = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round half up, then saturate to [-2^(OW-1), 2^(OW-1)-1]; sat_o SHALL be 1 when clipped.
REQ-021 SHALL use FSM states IDLE, SHIFT (DW address cycles), DRAIN (1 cycle, ROM latency) and HOLD (result presented).
REQ-022 SHALL assert in_ready only in IDLE; in_valid&in_ready latches x_i and row_sel and moves IDLE->SHIFT.
REQ-023 SHALL move SHIFT->DRAIN after the DW-th bit-plane, DRAIN->HOLD, and HOLD->IDLE on out_ready.
REQ-024 SHALL assert out_valid exactly DW+2 rising edges after the accepting edge, and hold y_o/sat_o stable until out_valid&out_ready.
REQ-025 SHALL ignore in_valid while not in IDLE and keep the latched operands.
REQ-026 SHALL hold y_o=0 and sat_o=0 whenever out_valid=0.
REQ-027 SHALL, when row_sel>=N_ROWS, use all-zero coefficients, giving y_o=0 and sat_o=0.

Reset
REQ-028 SHALL, on reset assertion, go to IDLE at any point including mid-SHIFT, discard the operation and clear the accumulator.
REQ-029 SHALL reset outputs to in_ready=1 after release, out_valid=0, y_o=0, sat_o=0.

Structure
REQ-030 SHALL place the coefficient table (N_ROWS x N_TAPS, CW-bit Q(FRAC)) and the FSM state encodings in shared package da_dct_pkg.
REQ-031 SHALL use one sub-module, da_coef_rom: synchronous read, 1-cycle latency, address {row, bit-plane}, contents generated from da_dct_pkg.

Verification (defaults; row 0 = all 512, row 1 = {724,-724,300,-300})
REQ-032 SHALL check: x={100,100,100,100}, row 0 -> y_o=200, sat_o=0, out_valid 14 cycles after accept.
REQ-033 SHALL check: x={1,0,0,0}, row 0 -> y_o=1 (0.5 rounds up); x={-1,0,0,0} -> y_o=0.
REQ-034 SHALL check: x all -2048, row 0 -> y_o=-2048, sat_o=1; x all 2047 -> y_o=2047, sat_o=1.
REQ-035 SHALL check: x={1000,0,-1000,0}, row 1 -> y_o=414; a second in_valid during SHIFT is ignored.
REQ-036 SHALL check: out_ready held low 5 cycles in HOLD -> y_o stable and in_ready=0; the transfer completes on out_ready=1 and in_ready=1 next cycle.
REQ-037 SHALL check: reset pulsed at SHIFT cycle 6 -> out_valid never rises for that vector; the next vector {100,100,100,100}, row 0 gives y_o=200.

Source files
------------

// File: rtl/da_dct_pkg.sv
// Shared definitions for the distributed-arithmetic DCT engine:
// FSM encoding, the Q10 coefficient table and the DA ROM entry generator.
package da_dct_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int MAX_ROWS = 8;
    localparam int MAX_TAPS = 8;

    // Row 0 is the DC basis; the remaining rows are DCT-like Q10 basis vectors.
    localparam int COEF_TBL [MAX_ROWS][MAX_TAPS] = '{
        '{ 512,  512,  512,  512,  512,  512,  512,  512},
        '{ 724, -724,  300, -300,  724, -724,  300, -300},
        '{ 669,  277, -277, -669, -669, -277,  277,  669},
        '{ 602, -141, -709, -400,  400,  709,  141, -602},
        '{ 512, -512, -512,  512,  512, -512, -512,  512},
        '{ 400, -709,  141,  602, -602, -141,  709, -400},
        '{ 277, -669,  669, -277, -277,  669, -669,  277},
        '{ 141, -400,  602, -709,  709, -602,  400, -141}
    };

    // Sum of the row's coefficients selected by a bit-plane address;
    // address bit (ntaps-1-k) selects tap k. Rows past the table are zero.
    function automatic int rom_entry(input int row, input int addr,
                                     input int ntaps, input int nrows);
        int s;
        s = 0;
        if (row < nrows && row < MAX_ROWS) begin
            for (int k = 0; k < ntaps && k < MAX_TAPS; k++) begin
                if (((addr >> (ntaps - 1 - k)) & 1) != 0)
                    s += COEF_TBL[3'(row)][3'(k)];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/da_coef_rom.sv
// Distributed-arithmetic coefficient ROM: one registered read per cycle,
// addressed by {row, bit-plane}; contents are built from da_dct_pkg.
module da_coef_rom
    import da_dct_pkg::*;
#(
    parameter int N_TAPS = 4,
    parameter int EW     = 14,
    parameter int N_ROWS = 8,
    parameter int RW     = 3
) (
    input  logic                 clk_i,
    input  logic [RW-1:0]        row_i,
    input  logic [N_TAPS-1:0]    plane_i,
    output logic signed [EW-1:0] data_o
);

    localparam int AW    = RW + N_TAPS;
    localparam int DEPTH = 1 << AW;

    logic signed [EW-1:0] tbl [DEPTH];
    logic signed [EW-1:0] data_q;

    for (genvar a = 0; a < DEPTH; a++) begin : g_tbl
        assign tbl[a] = EW'(rom_entry(a >> N_TAPS, a & ((1 << N_TAPS) - 1),
                                      N_TAPS, N_ROWS));
    end

    always_ff @(posedge clk_i) begin
        data_q <= tbl[{row_i, plane_i}];
    end

    assign data_o = data_q;

endmodule

// File: rtl/da_dct_engine.sv
// Bit-serial distributed-arithmetic dot product of N_TAPS samples against one
// coefficient row, with round-half-up and saturation on the result.
module da_dct_engine
    import da_dct_pkg::*;
#(
    parameter int N_TAPS = 4,
    parameter int DW     = 12,
    parameter int CW     = 12,
    parameter int OW     = 12,
    parameter int FRAC   = 10,
    parameter int N_ROWS = 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_TAPS*DW-1:0]   x_i,
    input  logic [$clog2(N_ROWS)-1:0] row_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OW-1:0]          y_o,
    output logic                   sat_o
);

    localparam int RW   = $clog2(N_ROWS);
    localparam int EW   = CW + $clog2(N_TAPS);
    localparam int AW   = CW + DW + $clog2(N_TAPS) + 1;
    localparam int CNTW = $clog2(DW);

    localparam logic signed [AW-1:0] HALF = AW'(64'd1 << (FRAC - 1));
    localparam logic signed [AW-1:0] YMAX = AW'((64'd1 << (OW - 1)) - 64'd1);
    localparam logic signed [AW-1:0] YMIN = ~YMAX;

    state_e                state_q, state_d;
    logic [N_TAPS*DW-1:0]  x_q, x_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic                  rd_vld_q, rd_first_q;
    logic signed [AW-1:0]  acc_q;
    logic                  out_valid_q, sat_q;
    logic [OW-1:0]         y_q;

    logic [DW-1:0]         taps [N_TAPS];
    logic [N_TAPS-1:0]     plane_addr;
    logic signed [EW-1:0]  rom_data;
    logic signed [AW-1:0]  rom_ext;
    logic [OW:0]           rs;
    logic                  xfer;

    function automatic logic [OW:0] round_sat(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] r;
        r = (a + HALF) >>> FRAC;
        if (r > YMAX)
            round_sat = {1'b1, YMAX[OW-1:0]};
        else if (r < YMIN)
            round_sat = {1'b1, YMIN[OW-1:0]};
        else
            round_sat = {1'b0, r[OW-1:0]};
    endfunction

    // Bit-plane address: address bit j comes from the packed slice j, which
    // holds tap N_TAPS-1-j because tap 0 sits in the MSBs.
    for (genvar j = 0; j < N_TAPS; j++) begin : g_plane
        assign taps[j]       = x_q[j*DW +: DW];
        assign plane_addr[j] = taps[j][cnt_q];
    end

    da_coef_rom #(
        .N_TAPS (N_TAPS),
        .EW     (EW),
        .N_ROWS (N_ROWS),
        .RW     (RW)
    ) u_rom (
        .clk_i   (sys_clk),
        .row_i   (row_q),
        .plane_i (plane_addr),
        .data_o  (rom_data)
    );

    assign rom_ext   = {{(AW-EW){rom_data[EW-1]}}, rom_data};
    assign rs        = round_sat(acc_q);
    assign xfer      = out_valid_q && out_ready;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign y_o       = y_q;
    assign sat_o     = sat_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x_i;
                    row_d   = row_sel;
                    cnt_d   = CNTW'(DW - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == '0)
                    state_d = DRAIN;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            DRAIN:   state_d = HOLD;
            HOLD:    if (xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    // ROM output lags the address by one cycle; track which plane it holds.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            rd_vld_q   <= (state_q == SHIFT);
            rd_first_q <= (state_q == SHIFT) && (cnt_q == CNTW'(DW - 1));
            if (rd_vld_q) begin
                if (rd_first_q)
                    acc_q <= -rom_ext;
                else
                    acc_q <= (acc_q <<< 1) + rom_ext;
            end
        end
    end

    // The first HOLD cycle registers the rounded result; it then stays put
    // until the downstream handshake.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            sat_q       <= 1'b0;
        end else if (state_q == HOLD && !out_valid_q) begin
            out_valid_q <= 1'b1;
            y_q         <= rs[OW-1:0];
            sat_q       <= rs[OW];
        end else if (xfer) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            sat_q       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_da_dct_engine.sv
// Directed and random checks of da_dct_engine with a result scoreboard.
module tb_da_dct_engine;

    localparam int NT  = 4;
    localparam int DW  = 12;
    localparam int OW  = 12;
    localparam int RWB = 3;
    localparam int LAT = DW + 2;

    typedef struct packed {
        logic signed [OW-1:0] y;
        logic                 sat;
    } exp_t;

    logic              sys_clk;
    logic              sys_rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NT*DW-1:0]  x_i;
    logic [RWB-1:0]    row_sel;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     y_o;
    logic              sat_o;

    exp_t sb [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    da_dct_engine dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_i       (x_i),
        .row_sel   (row_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_o       (y_o),
        .sat_o     (sat_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NT*DW-1:0] pack4(input int a, input int b,
                                               input int c, input int d);
        return {12'(a), 12'(b), 12'(c), 12'(d)};
    endfunction

    function automatic exp_t mk(input int y, input bit s);
        exp_t e;
        e.y   = OW'(y);
        e.sat = s;
        return e;
    endfunction

    function automatic int bcoef(input int row, input int k);
        if (row == 0) return 512;
        if (row == 1) begin
            case (k)
                0:       return 724;
                1:       return -724;
                2:       return 300;
                default: return -300;
            endcase
        end
        return 0;
    endfunction

    // Direct multiply-accumulate reference, independent of the DA structure.
    function automatic exp_t model(input logic [NT*DW-1:0] x, input int row);
        longint acc;
        longint r;
        logic signed [DW-1:0] s;
        acc = 0;
        for (int k = 0; k < NT; k++) begin
            s = x[(NT-1-k)*DW +: DW];
            acc += longint'(s) * longint'(bcoef(row, k));
        end
        r = (acc + 512) >>> 10;
        if (r > 2047) return mk(2047, 1'b1);
        if (r < -2048) return mk(-2048, 1'b1);
        return mk(int'(r), 1'b0);
    endfunction

    task automatic run_vec(input logic [NT*DW-1:0] x, input int row, input exp_t e,
                           input bit poke, input bit stall, input string tag);
        int   lat;
        bit   got;
        exp_t p;
        sb.push_back(e);
        @(negedge sys_clk);
        x_i       = x;
        row_sel   = RWB'(row);
        in_valid  = 1'b1;
        out_ready = !stall;
        chk({tag, " in_ready_idle"}, int'(in_ready), 1);
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        x_i      = pack4(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                         int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
        row_sel  = RWB'($urandom_range(0, 7));
        lat = 0;
        got = 1'b0;
        while (!got && lat < LAT + 20) begin
            @(posedge sys_clk);
            #1;
            lat++;
            if (poke) begin
                in_valid = (lat >= 3 && lat <= 5);
                if (lat == 4) chk({tag, " in_ready_busy"}, int'(in_ready), 0);
            end
            if (out_valid) got = 1'b1;
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, got ? lat : -1, LAT);
        if (got) begin
            p = sb.pop_front();
            chk({tag, " y_o"}, int'($signed(y_o)), int'(p.y));
            chk({tag, " sat_o"}, int'(sat_o), int'(p.sat));
            if (stall) begin
                repeat (5) begin
                    @(posedge sys_clk);
                    #1;
                    chk({tag, " y_stable"}, int'($signed(y_o)), int'(p.y));
                    chk({tag, " valid_held"}, int'(out_valid), 1);
                    chk({tag, " in_ready_hold"}, int'(in_ready), 0);
                end
                out_ready = 1'b1;
            end
            @(posedge sys_clk);
            #1;
            chk({tag, " valid_drop"}, int'(out_valid), 0);
            chk({tag, " y_zero"}, int'(y_o), 0);
            chk({tag, " sat_zero"}, int'(sat_o), 0);
            chk({tag, " in_ready_after"}, int'(in_ready), 1);
        end else begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        logic [NT*DW-1:0] rx;
        int  rrow;
        bit  rose;
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_i       = '0;
        row_sel   = '0;
        repeat (3) @(negedge sys_clk);
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst y_o", int'(y_o), 0);
        chk("rst sat_o", int'(sat_o), 0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("rel in_ready", int'(in_ready), 1);

        run_vec(pack4(100, 100, 100, 100), 0, mk(200, 1'b0), 1'b0, 1'b0, "dc100");
        run_vec(pack4(1, 0, 0, 0), 0, mk(1, 1'b0), 1'b0, 1'b0, "half_up");
        run_vec(pack4(-1, 0, 0, 0), 0, mk(0, 1'b0), 1'b0, 1'b0, "neg_half");
        run_vec(pack4(-2048, -2048, -2048, -2048), 0, mk(-2048, 1'b1), 1'b0, 1'b0, "sat_lo");
        run_vec(pack4(2047, 2047, 2047, 2047), 0, mk(2047, 1'b1), 1'b0, 1'b0, "sat_hi");
        run_vec(pack4(1000, 0, -1000, 0), 1, mk(414, 1'b0), 1'b1, 1'b0, "row1_poke");
        run_vec(pack4(1000, 0, -1000, 0), 1, mk(414, 1'b0), 1'b0, 1'b1, "stall");

        // Reset mid-SHIFT must abandon the vector entirely.
        @(negedge sys_clk);
        x_i      = pack4(2047, 2047, 2047, 2047);
        row_sel  = '0;
        in_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("midrst in_ready", int'(in_ready), 1);
        chk("midrst out_valid", int'(out_valid), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        rose = 1'b0;
        repeat (LAT + 10) begin
            @(posedge sys_clk);
            #1;
            if (out_valid) rose = 1'b1;
        end
        chk("midrst no_valid", int'(rose), 0);
        run_vec(pack4(100, 100, 100, 100), 0, mk(200, 1'b0), 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 6; i++) begin
            rx   = pack4(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                         int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
            rrow = i % 2;
            run_vec(rx, rrow, model(rx, rrow), 1'b0, 1'b0, "rand");
        end

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
